// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU write-back stage: the result byte, the
// destination select, the write-back FSM states and the small helper that
// maps a destination to the FSM state that services it.
package alu_writeback_pkg;

    typedef logic [7:0] BYTE;

    typedef enum logic [1:0] {
        DST_ACC   = 2'd0,
        DST_STACK = 2'd1,
        DST_HEAD  = 2'd2,
        DST_CACHE = 2'd3
    } ALU_DST;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WR_FAST    = 2'd1,
        WAIT_STACK = 2'd2,
        WAIT_CACHE = 2'd3
    } WB_STATE;

    // Accumulator and head complete in a single cycle; stack and cache
    // have to wait for their handshake.
    function automatic WB_STATE dst_to_state(input ALU_DST dst);
        WB_STATE st;
        case (dst)
            DST_ACC:   st = WR_FAST;
            DST_HEAD:  st = WR_FAST;
            DST_STACK: st = WAIT_STACK;
            DST_CACHE: st = WAIT_CACHE;
            default:   st = IDLE;
        endcase
        return st;
    endfunction

    function automatic logic byte_is_zero(input BYTE value);
        return (value == 8'h00);
    endfunction

endpackage

// File: rtl/alu_writeback_stall_timer.sv
// Stall timer for write-back WAIT states: counts wait cycles without a
// handshake and flags the cycle in which the next miss would hit the limit.
module wb_stall_timer #(
    parameter int STALL_LIMIT = 15,
    parameter int CNT_W       = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter: clear has priority over count enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The current cycle is the last one a request may still be serviced in.
    assign last = (cnt_r == CNT_W'(STALL_LIMIT - 1));

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back stage: latches one ALU result, drives the write strobe of
// the selected destination, waits for stack/cache handshakes with a stall
// timeout, and back-pressures the control unit while a write is pending.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int STALL_LIMIT = 15,
    parameter int CNT_W       = 4
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   wb_valid_i,
    output logic   wb_ready_o,
    input  ALU_DST wb_dst_i,
    input  BYTE    alu_out,
    input  logic   flush_i,
    output logic   acc_we_o,
    output logic   head_we_o,
    output logic   stack_push_o,
    input  logic   stack_ready_i,
    output logic   cache_we_o,
    input  logic   cache_ack_i,
    output BYTE    wb_data_o,
    output logic   zero_o,
    output logic   busy_o,
    output logic   err_o
);

    WB_STATE state_r;
    WB_STATE state_s;
    ALU_DST  dst_r;
    BYTE     data_r;
    logic    zero_r;
    logic    err_r;

    logic    in_wait_s;
    logic    hs_s;
    logic    ready_s;
    logic    accept_s;
    logic    timeout_s;
    logic    last_s;
    logic    tmr_clr_s;
    logic    tmr_en_s;

    // Handshake select, ready, accept, timeout and next-state decision.
    always_comb begin
        in_wait_s = 1'b0;
        hs_s      = 1'b0;
        case (state_r)
            WAIT_STACK: begin
                in_wait_s = 1'b1;
                hs_s      = stack_ready_i;
            end
            WAIT_CACHE: begin
                in_wait_s = 1'b1;
                hs_s      = cache_ack_i;
            end
            default: begin
                in_wait_s = 1'b0;
                hs_s      = 1'b0;
            end
        endcase

        if (flush_i) begin
            ready_s = 1'b0;
        end else if (in_wait_s) begin
            ready_s = hs_s;
        end else begin
            ready_s = 1'b1;
        end

        accept_s  = wb_valid_i && ready_s;
        timeout_s = in_wait_s && !hs_s && last_s && !flush_i;

        if (flush_i) begin
            state_s = IDLE;
        end else if (accept_s) begin
            state_s = dst_to_state(wb_dst_i);
        end else if (in_wait_s && !hs_s && !timeout_s) begin
            state_s = state_r;
        end else begin
            state_s = IDLE;
        end

        tmr_clr_s = flush_i || accept_s || timeout_s;
        tmr_en_s  = in_wait_s && !hs_s && !tmr_clr_s;
    end

    // FSM state and latched destination.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            dst_r   <= DST_ACC;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                dst_r <= wb_dst_i;
            end else begin
                dst_r <= dst_r;
            end
        end
    end

    // Result register and zero flag, loaded only on accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= 8'h00;
            zero_r <= 1'b1;
        end else if (accept_s) begin
            data_r <= alu_out;
            zero_r <= byte_is_zero(alu_out);
        end else begin
            data_r <= data_r;
            zero_r <= zero_r;
        end
    end

    // Sticky stall-timeout flag; flush is the only way to clear it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if (flush_i) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    wb_stall_timer #(
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (CNT_W)
    ) u_stall_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .last    (last_s)
    );

    // Strobes decode from registered state only, so they are glitch-free
    // with respect to the inputs and drop immediately on async reset.
    assign acc_we_o     = (state_r == WR_FAST) && (dst_r == DST_ACC);
    assign head_we_o    = (state_r == WR_FAST) && (dst_r == DST_HEAD);
    assign stack_push_o = (state_r == WAIT_STACK);
    assign cache_we_o   = (state_r == WAIT_CACHE);
    assign busy_o       = (state_r != IDLE);
    assign wb_ready_o   = ready_s;
    assign wb_data_o    = data_r;
    assign zero_o       = zero_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback: hand-computed expectations for
// reset, fast writes, stack/cache handshakes, stall timeout and flush.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    logic   clock;
    logic   reset_n;
    logic   wb_valid_i;
    logic   wb_ready_o;
    ALU_DST wb_dst_i;
    BYTE    alu_out;
    logic   flush_i;
    logic   acc_we_o;
    logic   head_we_o;
    logic   stack_push_o;
    logic   stack_ready_i;
    logic   cache_we_o;
    logic   cache_ack_i;
    BYTE    wb_data_o;
    logic   zero_o;
    logic   busy_o;
    logic   err_o;

    int n_tests;
    int n_failed;

    alu_writeback #(.STALL_LIMIT(15), .CNT_W(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wb_valid_i    (wb_valid_i),
        .wb_ready_o    (wb_ready_o),
        .wb_dst_i      (wb_dst_i),
        .alu_out       (alu_out),
        .flush_i       (flush_i),
        .acc_we_o      (acc_we_o),
        .head_we_o     (head_we_o),
        .stack_push_o  (stack_push_o),
        .stack_ready_i (stack_ready_i),
        .cache_we_o    (cache_we_o),
        .cache_ack_i   (cache_ack_i),
        .wb_data_o     (wb_data_o),
        .zero_o        (zero_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input ALU_DST dst, input BYTE data);
        wb_valid_i = 1'b1;
        wb_dst_i   = dst;
        alu_out    = data;
        #1;
        check_eq("send_ready", 32'(wb_ready_o), 32'd1);
        tick();
        wb_valid_i = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_failed      = 0;
        reset_n       = 1'b0;
        wb_valid_i    = 1'b0;
        wb_dst_i      = DST_ACC;
        alu_out       = 8'h00;
        flush_i       = 1'b0;
        stack_ready_i = 1'b0;
        cache_ack_i   = 1'b0;

        // Reset state
        #12;
        check_eq("rst_data",  32'(wb_data_o), 32'h00);
        check_eq("rst_zero",  32'(zero_o), 32'd1);
        check_eq("rst_busy",  32'(busy_o), 32'd0);
        check_eq("rst_err",   32'(err_o), 32'd0);
        check_eq("rst_strb",  32'({acc_we_o, head_we_o, stack_push_o, cache_we_o}), 32'd0);
        reset_n = 1'b1;
        tick();

        // Back-to-back ACC 03 then HEAD 00
        send(DST_ACC, 8'h03);
        wb_valid_i = 1'b1;
        wb_dst_i   = DST_HEAD;
        alu_out    = 8'h00;
        #1;
        check_eq("b2b_acc_we",  32'(acc_we_o), 32'd1);
        check_eq("b2b_head0",   32'(head_we_o), 32'd0);
        check_eq("b2b_data03",  32'(wb_data_o), 32'h03);
        check_eq("b2b_zero0",   32'(zero_o), 32'd0);
        check_eq("b2b_ready1",  32'(wb_ready_o), 32'd1);
        tick();
        wb_valid_i = 1'b0;
        #1;
        check_eq("b2b_head_we", 32'(head_we_o), 32'd1);
        check_eq("b2b_acc0",    32'(acc_we_o), 32'd0);
        check_eq("b2b_data00",  32'(wb_data_o), 32'h00);
        check_eq("b2b_zero1",   32'(zero_o), 32'd1);
        check_eq("b2b_ready2",  32'(wb_ready_o), 32'd1);
        tick();
        #1;
        check_eq("b2b_idle_strb", 32'({acc_we_o, head_we_o}), 32'd0);
        check_eq("b2b_idle_busy", 32'(busy_o), 32'd0);

        // STACK FF, ready after 3 stalls, queued ACC 11
        send(DST_STACK, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            stack_ready_i = 1'b0;
            #1;
            check_eq("stk_push", 32'(stack_push_o), 32'd1);
            check_eq("stk_ready0", 32'(wb_ready_o), 32'd0);
            check_eq("stk_busy", 32'(busy_o), 32'd1);
            tick();
        end
        stack_ready_i = 1'b1;
        wb_valid_i    = 1'b1;
        wb_dst_i      = DST_ACC;
        alu_out       = 8'h11;
        #1;
        check_eq("stk_push4",  32'(stack_push_o), 32'd1);
        check_eq("stk_ready1", 32'(wb_ready_o), 32'd1);
        check_eq("stk_dataFF", 32'(wb_data_o), 32'hFF);
        tick();
        stack_ready_i = 1'b0;
        wb_valid_i    = 1'b0;
        #1;
        check_eq("stk_push_off", 32'(stack_push_o), 32'd0);
        check_eq("stk_acc_we",   32'(acc_we_o), 32'd1);
        check_eq("stk_data11",   32'(wb_data_o), 32'h11);
        tick();

        // CACHE 42 never acknowledged: 15 cycles then timeout
        send(DST_CACHE, 8'h42);
        for (int i = 0; i < 15; i++) begin
            #1;
            check_eq("to_cache_we", 32'(cache_we_o), 32'd1);
            check_eq("to_err0", 32'(err_o), 32'd0);
            tick();
        end
        #1;
        check_eq("to_cache_off", 32'(cache_we_o), 32'd0);
        check_eq("to_err1",      32'(err_o), 32'd1);
        check_eq("to_busy0",     32'(busy_o), 32'd0);
        check_eq("to_data42",    32'(wb_data_o), 32'h42);
        send(DST_ACC, 8'h55);
        #1;
        check_eq("to_acc_we",    32'(acc_we_o), 32'd1);
        check_eq("to_err_stick", 32'(err_o), 32'd1);
        check_eq("to_data55",    32'(wb_data_o), 32'h55);
        tick();

        // Flush during WAIT_STACK with err set; late ready ignored
        send(DST_STACK, 8'h77);
        flush_i    = 1'b1;
        wb_valid_i = 1'b1;
        wb_dst_i   = DST_ACC;
        alu_out    = 8'h99;
        #1;
        check_eq("fl_push_before", 32'(stack_push_o), 32'd1);
        check_eq("fl_ready0",      32'(wb_ready_o), 32'd0);
        tick();
        flush_i       = 1'b0;
        wb_valid_i    = 1'b0;
        stack_ready_i = 1'b1;
        #1;
        check_eq("fl_push0", 32'(stack_push_o), 32'd0);
        check_eq("fl_err0",  32'(err_o), 32'd0);
        check_eq("fl_busy0", 32'(busy_o), 32'd0);
        check_eq("fl_data",  32'(wb_data_o), 32'h77);
        check_eq("fl_acc0",  32'(acc_we_o), 32'd0);
        tick();
        #1;
        check_eq("fl_late_busy", 32'(busy_o), 32'd0);
        stack_ready_i = 1'b0;

        // CACHE 9C acked in the limit cycle: normal completion
        send(DST_CACHE, 8'h9C);
        for (int i = 0; i < 14; i++) begin
            #1;
            check_eq("lim_cache_we", 32'(cache_we_o), 32'd1);
            tick();
        end
        cache_ack_i = 1'b1;
        #1;
        check_eq("lim_cache_last", 32'(cache_we_o), 32'd1);
        check_eq("lim_ready1",     32'(wb_ready_o), 32'd1);
        tick();
        cache_ack_i = 1'b0;
        #1;
        check_eq("lim_cache_off", 32'(cache_we_o), 32'd0);
        check_eq("lim_err0",      32'(err_o), 32'd0);
        check_eq("lim_busy0",     32'(busy_o), 32'd0);
        check_eq("lim_data9C",    32'(wb_data_o), 32'h9C);
        tick();

        // Async reset mid-WAIT_STACK with 5A pending
        send(DST_STACK, 8'h5A);
        #1;
        check_eq("ar_push1", 32'(stack_push_o), 32'd1);
        check_eq("ar_data",  32'(wb_data_o), 32'h5A);
        reset_n = 1'b0;
        #1;
        check_eq("ar_push0", 32'(stack_push_o), 32'd0);
        check_eq("ar_data0", 32'(wb_data_o), 32'h00);
        check_eq("ar_zero1", 32'(zero_o), 32'd1);
        check_eq("ar_busy0", 32'(busy_o), 32'd0);
        reset_n = 1'b1;
        tick();
        #1;
        check_eq("ar_after_push", 32'(stack_push_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
